// File: rtl/qcs_gpio_drive_sched.sv
// Round-robin scheduler that shares one GPIO bus between requesters, with a turnaround gap after each drive.
// Define QCS_GPIO_DRIVE_SCHED_CHECK_EN to add the sticky bus read-back check (chk_err/chk_err_req).
module qcs_gpio_drive_sched #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int HOLD_W    = 8,
    parameter int TA_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*HOLD_W-1:0]    req_hold,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           done,
    output logic [WIDTH-1:0]             gpio_o,
    output logic                         gpio_oe,
    input  logic [WIDTH-1:0]             gpio_i,
`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
    output logic                         chk_err,
    output logic [$clog2(NUM_REQ)-1:0]   chk_err_req,
`endif
    output logic                         busy
);
    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]    NUM_EXT  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [3:0]        TA_INIT  = 4'(TA_CYCLES);
    localparam logic [HOLD_W-1:0] ONE      = HOLD_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;
    logic [3:0]         ta_q, ta_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [WIDTH-1:0]   gpio_q, gpio_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;

    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand;
    logic [WIDTH-1:0]   sel_data;
    logic [HOLD_W-1:0]  sel_hold;

    // Walk offsets from the highest down so the smallest offset from ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (req[cand[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_hold = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
                sel_hold = req_hold[i*HOLD_W +: HOLD_W];
            end
        end
    end

    // Outputs are derived from the next state so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ta_d    = ta_q;
        ack_d   = '0;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_DRIVE;
                    win_d   = grant_idx;
                    data_d  = sel_data;
                    cnt_d   = (sel_hold == '0) ? ONE : sel_hold;
                    ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q <= ONE) begin
                    cnt_d = '0;
                    if (TA_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TURN;
                        ta_d    = TA_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_TURN: begin
                if (ta_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    ta_d    = '0;
                end else begin
                    ta_d = ta_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        oe_d   = (state_d == ST_DRIVE);
        busy_d = (state_d != ST_IDLE);
        gpio_d = oe_d ? data_d : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i]  = (state_q == ST_IDLE) && grant_valid && (grant_idx == PTR_W'(i));
            done_d[i] = oe_d && (cnt_d == ONE) && (win_d == PTR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ta_q    <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            gpio_q  <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ta_q    <= ta_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            gpio_q  <= gpio_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign gpio_o  = gpio_q;
    assign gpio_oe = oe_q;
    assign busy    = busy_q;

`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
    logic             chk_err_q;
    logic [PTR_W-1:0] chk_req_q;
    logic             last_drive;

    assign last_drive = (state_q == ST_DRIVE) && (cnt_q == ONE);

    // Only the first mismatch is recorded; later ones leave the index untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
            chk_req_q <= '0;
        end else if (!chk_err_q && last_drive && (gpio_i != data_q)) begin
            chk_err_q <= 1'b1;
            chk_req_q <= win_q;
        end
    end

    assign chk_err     = chk_err_q;
    assign chk_err_req = chk_req_q;
`else
    logic unused_gpio_i;
    assign unused_gpio_i = ^gpio_i;
`endif

endmodule

// File: tb/tb_qcs_gpio_drive_sched.sv
// Self-checking bench for qcs_gpio_drive_sched: directed scenarios plus a randomized run
// checked against a transaction-level round-robin timing model.
`timescale 1ns/1ps
module tb_qcs_gpio_drive_sched;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int HOLD_W  = 8;
    localparam int TA      = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [31:0] req_data;
    logic [31:0] req_hold;
    logic [7:0]  gpio_i;
    logic [3:0]  ack, done, ack0, done0;
    logic [7:0]  gpio_o, gpio0_o;
    logic        gpio_oe, gpio0_oe, busy, busy0;
`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
    logic        chk_err, chk0_err;
    logic [1:0]  chk_err_req, chk0_err_req;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    qcs_gpio_drive_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .TA_CYCLES(TA)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_hold(req_hold),
        .ack(ack), .done(done), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .gpio_i(gpio_i),
`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
        .chk_err(chk_err), .chk_err_req(chk_err_req),
`endif
        .busy(busy)
    );

    qcs_gpio_drive_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .TA_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .req_data(req_data), .req_hold(req_hold),
        .ack(ack0), .done(done0), .gpio_o(gpio0_o), .gpio_oe(gpio0_oe), .gpio_i(gpio_i),
`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
        .chk_err(chk0_err), .chk_err_req(chk0_err_req),
`endif
        .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        req0  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = '0;
        req0     = '0;
        req_data = '0;
        req_hold = '0;
        gpio_i   = '0;
        #1;
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, 18'h0);
        end
        tests_run++;
        if ({ack0, done0, gpio0_oe, gpio0_o, busy0} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs_ta0: got %h want %h", {ack0, done0, gpio0_oe, gpio0_o, busy0}, 18'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, 18'h0);
        end
    endtask

    task automatic test_single();
        logic [17:0] want;
        req_data[7:0] = 8'hA5;
        req_hold[7:0] = 8'd3;
        req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            want = {(c == 1) ? 4'b0001 : 4'b0000, (c == 3) ? 4'b0001 : 4'b0000,
                    c <= 3, (c <= 3) ? 8'hA5 : 8'h00, c <= 5};
            tests_run++;
            if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
                tests_failed++;
                $display("[TB] FAIL single c%0d: got %h want %h", c, {ack, done, gpio_oe, gpio_o, busy}, want);
            end
            req = '0;
        end
    endtask

    task automatic test_round_robin();
        int rr_hold[4] = '{1, 2, 3, 0};
        int ack_cyc[$];
        int ack_win[$];
        int cyc = 0;
        int w, ew, pw, gap;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'(8'h10 + i);
            req_hold[i*8 +: 8] = 8'(rr_hold[i]);
        end
        req = 4'hF;
        while (ack_cyc.size() < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                w = -1;
                if ($onehot(ack)) begin
                    for (int b = 0; b < 4; b++) if (ack[b]) w = b;
                end
                ack_cyc.push_back(cyc);
                ack_win.push_back(w);
                if (ack_cyc.size() == 5) req = '0;
            end
        end
        tests_run++;
        if (ack_cyc.size() != 5) begin
            tests_failed++;
            $display("[TB] FAIL rr_ack_count: got %0d want 5", ack_cyc.size());
        end
        for (int n = 0; n < ack_cyc.size(); n++) begin
            ew = n % 4;
            tests_run++;
            if (ack_win[n] != ew) begin
                tests_failed++;
                $display("[TB] FAIL rr_order n%0d: got %0d want %0d", n, ack_win[n], ew);
            end
            if (n > 0) begin
                pw  = (n - 1) % 4;
                gap = ((rr_hold[pw] == 0) ? 1 : rr_hold[pw]) + TA + 1;
                tests_run++;
                if (ack_cyc[n] - ack_cyc[n-1] != gap) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_spacing n%0d: got %0d want %0d", n, ack_cyc[n] - ack_cyc[n-1], gap);
                end
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_hold_zero();
        logic [17:0] want;
        req_data[23:16] = 8'hC3;
        req_hold[23:16] = 8'd0;
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            want = {(c == 1) ? 4'b0100 : 4'b0000, (c == 1) ? 4'b0100 : 4'b0000,
                    c == 1, (c == 1) ? 8'hC3 : 8'h00, c <= 3};
            tests_run++;
            if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
                tests_failed++;
                $display("[TB] FAIL hold_zero c%0d: got %h want %h", c, {ack, done, gpio_oe, gpio_o, busy}, want);
            end
            req = '0;
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] want;
        req_data[23:16] = 8'h5A;
        req_hold[23:16] = 8'd5;
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        want = {4'b0000, 4'b0000, 1'b1, 8'h5A, 1'b1};
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
            tests_failed++;
            $display("[TB] FAIL mid_second_drive: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, want);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_async_reset: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, 18'h0);
        end
        @(negedge clk);
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_no_done: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, 18'h0);
        end
        rst_n = 1'b1;
        req_data[15:8]  = 8'h21;
        req_hold[15:8]  = 8'd1;
        req_data[31:24] = 8'h43;
        req_hold[31:24] = 8'd1;
        req = 4'b1010;
        @(negedge clk);
        want = {4'b0010, 4'b0010, 1'b1, 8'h21, 1'b1};
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
            tests_failed++;
            $display("[TB] FAIL ptr_after_reset: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, want);
        end
        req = '0;
        repeat (3) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        want = {4'b1000, 4'b1000, 1'b1, 8'h43, 1'b1};
        tests_run++;
        if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
            tests_failed++;
            $display("[TB] FAIL req3_after_reset: got %h want %h", {ack, done, gpio_oe, gpio_o, busy}, want);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ta_zero();
        logic [17:0] tbl[5];
        tbl[0] = {4'b0010, 4'b0000, 1'b1, 8'h96, 1'b1};
        tbl[1] = {4'b0000, 4'b0010, 1'b1, 8'h96, 1'b1};
        tbl[2] = 18'h0;
        tbl[3] = {4'b0100, 4'b0100, 1'b1, 8'h69, 1'b1};
        tbl[4] = 18'h0;
        req_data[15:8]  = 8'h96;
        req_hold[15:8]  = 8'd2;
        req_data[23:16] = 8'h69;
        req_hold[23:16] = 8'd1;
        req0 = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({ack0, done0, gpio0_oe, gpio0_o, busy0} !== tbl[c]) begin
                tests_failed++;
                $display("[TB] FAIL ta_zero c%0d: got %h want %h", c + 1, {ack0, done0, gpio0_oe, gpio0_o, busy0}, tbl[c]);
            end
            if (c == 3) req0 = '0;
        end
    endtask

    task automatic test_random();
        int          mptr = 0;
        int          w, h, idx;
        logic [3:0]  mask;
        logic [7:0]  d;
        logic [17:0] want;
        logic        oe;
        apply_reset();
        for (int g = 0; g < 30; g++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                req_data[i*8 +: 8] = 8'($urandom);
                req_hold[i*8 +: 8] = (g == 10) ? 8'hFF : 8'($urandom_range(0, 4));
            end
            req = mask;
            w = -1;
            for (int o = 0; o < 4; o++) begin
                idx = (mptr + o) % 4;
                if (w < 0 && mask[idx]) w = idx;
            end
            h = int'(req_hold[w*8 +: 8]);
            if (h == 0) h = 1;
            d = req_data[w*8 +: 8];
            mptr = (w + 1) % 4;
            for (int c = 1; c <= h + TA + 1; c++) begin
                @(negedge clk);
                oe = (c <= h);
                want = {(c == 1) ? 4'(1 << w) : 4'b0000, (c == h) ? 4'(1 << w) : 4'b0000,
                        oe, oe ? d : 8'h00, c <= h + TA};
                tests_run++;
                if ({ack, done, gpio_oe, gpio_o, busy} !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL random g%0d c%0d: got %h want %h", g, c, {ack, done, gpio_oe, gpio_o, busy}, want);
                end
                if (c < h + TA + 1) begin
                    req      = 4'($urandom);
                    req_data = $urandom;
                    req_hold = $urandom;
                end
            end
        end
        req = '0;
    endtask

`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
    task automatic test_check();
        apply_reset();
        tests_run++;
        if ({chk_err, chk_err_req} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL chk_reset: got %b want 000", {chk_err, chk_err_req});
        end
        gpio_i = 8'h11;
        req_data[7:0] = 8'h11;
        req_hold[7:0] = 8'd1;
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({chk_err, chk_err_req} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL chk_match: got %b want 000", {chk_err, chk_err_req});
        end
        gpio_i = 8'h00;
        req_data[15:8] = 8'h3C;
        req_hold[15:8] = 8'd2;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({chk_err, chk_err_req} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL chk_first: got %b want 101", {chk_err, chk_err_req});
        end
        req_data[23:16] = 8'h77;
        req_hold[23:16] = 8'd1;
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({chk_err, chk_err_req} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL chk_sticky: got %b want 101", {chk_err, chk_err_req});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_zero();
        test_reset_mid();
        test_ta_zero();
        test_random();
`ifdef QCS_GPIO_DRIVE_SCHED_CHECK_EN
        test_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
